// File: rtl/hba_bus_arbiter_pkg.sv
// Shared HBA arbiter definitions: FSM state encoding, idle-bus values, default widths.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package hba_bus_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } hba_state_e;

  // Value the bus shows when nobody owns it. Address and data idle at zero.
  localparam logic HBA_IDLE_RWN = 1'b1;

  // Default widths used by every HBA peripheral (4-bit periph + 8-bit reg address).
  localparam int HBA_DBUS_WIDTH = 8;
  localparam int HBA_ADDR_WIDTH = 12;

  // $clog2 with a floor of one bit, so degenerate parameters still give a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hba_bus_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after the pointer, wrapping.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether to register the pick.
// Ports:
//   req_i   in  NUM_MASTERS  request vector
//   ptr_i   in  PW           index of the most recent owner
//   pick_o  out NUM_MASTERS  one-hot winner (zero when no request)
//   vld_o   out 1            at least one request present
module hba_bus_arbiter_rr_picker
  import hba_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int PW          = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [PW-1:0]          ptr_i,
  output logic [NUM_MASTERS-1:0] pick_o,
  output logic                   vld_o
);

  logic found;

  // Walk the candidates in rotation order ptr+1, ptr+2, ... and take the first requester.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % NUM_MASTERS))) begin
          pick_o[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/hba_bus_arbiter.sv
// Round-robin owner arbiter for the shared HBA bus with transfer-count preemption.
// Latency: req->grant 1 clk; grant->bus outputs 0 clk (combinational mux of registered grant).
// Backpressure: non-owners wait until the owner drops req or hits MAX_XFERS acked transfers.
// Ports:
//   hba_clk, hba_reset_n            clock, async active-low reset
//   master_req/rwn/abus/dbus        per-master request and bus cycle (flattened vectors)
//   master_grant                    registered one-hot grant
//   hba_xferack                     slave ack of the current bus cycle
//   hba_select/rwn/abus/dbus        muxed bus cycle of the owner, idle values otherwise
module hba_bus_arbiter
  import hba_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DBUS_WIDTH  = HBA_DBUS_WIDTH,
  parameter int ADDR_WIDTH  = HBA_ADDR_WIDTH,
  parameter int MAX_XFERS   = 16
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset_n,
  input  logic [NUM_MASTERS-1:0]            master_req,
  output logic [NUM_MASTERS-1:0]            master_grant,
  input  logic [NUM_MASTERS-1:0]            master_rwn,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
  input  logic                              hba_xferack,
  output logic                              hba_select,
  output logic                              hba_rwn,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic [DBUS_WIDTH-1:0]             hba_dbus
);

  localparam int PW     = clog2_min1(NUM_MASTERS);
  localparam int CW     = clog2_min1(MAX_XFERS + 1);
  localparam int LAST_I = (MAX_XFERS > 0) ? MAX_XFERS - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
  // Pointer starts on the last master so master 0 wins the first arbitration.
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_MASTERS - 1);

  hba_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_vld;
  logic [PW-1:0]          owner_idx;
  logic                   owner_req;
  logic                   select;
  logic                   ack_en;
  logic                   preempt;
  logic                   rwn_or;
  logic [ADDR_WIDTH-1:0]  abus_or;
  logic [DBUS_WIDTH-1:0]  dbus_or;

  hba_bus_arbiter_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_picker (
    .req_i  (master_req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .vld_o  (pick_vld)
  );

  // Encode the one-hot grant so the pointer can remember who owned the bus last.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  assign owner_req = |(grant_q & master_req);
  assign select    = (state_q == ST_OWNED) && owner_req;
  assign ack_en    = select && hba_xferack;
  // The ack that brings the tenure to MAX_XFERS forces a release on this edge.
  assign preempt   = (MAX_XFERS != 0) && ack_en && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OWNED: begin
        if (!owner_req || preempt) begin
          state_d = ST_RELEASE;
          grant_d = '0;
          ptr_d   = owner_idx;
          cnt_d   = '0;
        end else if (ack_en && (cnt_q != {CW{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and the single RELEASE dead cycle both arbitrate for the next edge.
        cnt_d = '0;
        if (pick_vld) begin
          state_d = ST_OWNED;
          grant_d = pick;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // AND-OR mux over the one-hot grant.
  always_comb begin
    rwn_or  = 1'b0;
    abus_or = '0;
    dbus_or = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rwn_or  = rwn_or  | (master_rwn[i] & grant_q[i]);
      abus_or = abus_or | (master_abus[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
      dbus_or = dbus_or | (master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
    end
  end

  assign master_grant = grant_q;
  assign hba_select   = select;
  assign hba_rwn      = select ? rwn_or  : HBA_IDLE_RWN;
  assign hba_abus     = select ? abus_or : '0;
  assign hba_dbus     = select ? dbus_or : '0;

endmodule

// File: tb/tb_hba_bus_arbiter.sv
// Directed bench for the HBA round-robin arbiter (2 masters, MAX_XFERS = 4).
// Latency: checks registered grant one edge after requests, bus outputs combinationally.
// Backpressure: exercises hold-off, release gap and preemption.
module tb_hba_bus_arbiter;

  logic        hba_clk = 1'b0;
  logic        hba_reset_n;
  logic [1:0]  master_req;
  logic [1:0]  master_grant;
  logic [1:0]  master_rwn;
  logic [23:0] master_abus;
  logic [15:0] master_dbus;
  logic        hba_xferack;
  logic        hba_select;
  logic        hba_rwn;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;

  int n_chk;
  int n_fail;

  hba_bus_arbiter #(
    .NUM_MASTERS (2),
    .DBUS_WIDTH  (8),
    .ADDR_WIDTH  (12),
    .MAX_XFERS   (4)
  ) dut (
    .hba_clk      (hba_clk),
    .hba_reset_n  (hba_reset_n),
    .master_req   (master_req),
    .master_grant (master_grant),
    .master_rwn   (master_rwn),
    .master_abus  (master_abus),
    .master_dbus  (master_dbus),
    .hba_xferack  (hba_xferack),
    .hba_select   (hba_select),
    .hba_rwn      (hba_rwn),
    .hba_abus     (hba_abus),
    .hba_dbus     (hba_dbus)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hba_clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"},  32'(hba_select), 32'h0);
    check({tag, "_rwn"},  32'(hba_rwn),    32'h1);
    check({tag, "_abus"}, 32'(hba_abus),   32'h0);
    check({tag, "_dbus"}, 32'(hba_dbus),   32'h0);
  endtask

  // Master 0 issues a write to 0x123 with data 0x5A.
  task automatic check_bus_m0(input string tag);
    check({tag, "_sel"},  32'(hba_select), 32'h1);
    check({tag, "_rwn"},  32'(hba_rwn),    32'h0);
    check({tag, "_abus"}, 32'(hba_abus),   32'h123);
    check({tag, "_dbus"}, 32'(hba_dbus),   32'h5A);
  endtask

  // Master 1 issues a read of 0xABC (data lines carry 0xC3).
  task automatic check_bus_m1(input string tag);
    check({tag, "_sel"},  32'(hba_select), 32'h1);
    check({tag, "_rwn"},  32'(hba_rwn),    32'h1);
    check({tag, "_abus"}, 32'(hba_abus),   32'hABC);
    check({tag, "_dbus"}, 32'(hba_dbus),   32'hC3);
  endtask

  initial begin
    logic [1:0] exp;
    n_chk       = 0;
    n_fail      = 0;
    master_rwn  = 2'b10;
    master_abus = {12'hABC, 12'h123};
    master_dbus = {8'hC3, 8'h5A};

    // 1. Reset held with requests and acks active.
    hba_reset_n = 1'b0;
    master_req  = 2'b11;
    hba_xferack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_grant", 32'(master_grant), 32'h0);
      check_idle("rst_bus");
    end
    master_req  = 2'b00;
    hba_xferack = 1'b0;
    hba_reset_n = 1'b1;
    #1;
    check("rst_rel_grant", 32'(master_grant), 32'h0);

    // 2. Single master: grant one clock after req, bus follows owner.
    repeat (4) tick();
    master_req = 2'b01;
    #1;
    check("t2_pre_grant", 32'(master_grant), 32'h0);
    check_idle("t2_pre_bus");
    tick();
    check("t2_grant", 32'(master_grant), 32'h1);
    check_bus_m0("t2_bus");
    tick();
    check("t2_hold", 32'(master_grant), 32'h1);
    master_req = 2'b00;
    #1;
    check("t2_drop_grant", 32'(master_grant), 32'h1);
    check_idle("t2_drop_bus");
    tick();
    check("t2_release", 32'(master_grant), 32'h0);
    master_req = 2'b01;
    #1;
    check("t2_rel_req", 32'(master_grant), 32'h0);
    tick();
    check("t2_regrant", 32'(master_grant), 32'h1);
    master_req = 2'b00;
    tick();
    check("t2_rel2", 32'(master_grant), 32'h0);
    tick();
    check("t2_idle", 32'(master_grant), 32'h0);
    check_idle("t2_idle_bus");

    // 3. Contention from reset, strict alternation over 10 handoffs.
    hba_reset_n = 1'b0;
    master_req  = 2'b11;
    #1;
    check("t3_rst", 32'(master_grant), 32'h0);
    tick();
    hba_reset_n = 1'b1;
    tick();
    check("t3_first", 32'(master_grant), 32'h1);
    exp = 2'b01;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("t3_hold", 32'(master_grant), 32'(exp));
      master_req = 2'b11 & ~exp;
      tick();
      check("t3_release", 32'(master_grant), 32'h0);
      master_req = 2'b11;
      tick();
      exp = {exp[0], exp[1]};
      check("t3_rotate", 32'(master_grant), 32'(exp));
    end

    // 4. Preemption: M0 owns with a fresh count, ack every cycle, M1 waiting.
    hba_xferack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t4_m0_ack", 32'(master_grant), 32'h1);
    end
    tick();
    check("t4_preempt", 32'(master_grant), 32'h0);
    check_idle("t4_preempt_bus");
    hba_xferack = 1'b0;
    tick();
    check("t4_m1_grant", 32'(master_grant), 32'h2);
    check_bus_m1("t4_m1_bus");
    master_req = 2'b01;
    tick();
    check("t4_m1_rel", 32'(master_grant), 32'h0);
    tick();
    check("t4_m0_regrant", 32'(master_grant), 32'h1);

    // 5a. Owner drops req on the 4th ack: one RELEASE cycle only.
    hba_xferack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t5a_ack", 32'(master_grant), 32'h1);
    end
    master_req = 2'b00;
    #1;
    check_idle("t5a_drop_bus");
    tick();
    check("t5a_release", 32'(master_grant), 32'h0);
    master_req = 2'b01;
    tick();
    check("t5a_regrant", 32'(master_grant), 32'h1);
    // Count restarted: preempted again after exactly four acks, then 1-cycle gap.
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t5a_cnt_reset", 32'(master_grant), 32'h1);
    end
    tick();
    check("t5a_preempt", 32'(master_grant), 32'h0);
    tick();
    check("t5a_gap_regrant", 32'(master_grant), 32'h1);

    // 5b. Acks while the bus is idle are ignored.
    master_req = 2'b00;
    tick();
    check("t5b_release", 32'(master_grant), 32'h0);
    tick();
    hba_xferack = 1'b0;
    tick();
    hba_xferack = 1'b1;
    tick();
    check("t5b_idle", 32'(master_grant), 32'h0);
    check_idle("t5b_idle_bus");
    master_req = 2'b01;
    tick();
    check("t5b_grant", 32'(master_grant), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t5b_ack", 32'(master_grant), 32'h1);
    end
    tick();
    check("t5b_preempt", 32'(master_grant), 32'h0);

    // 6. Async reset in the middle of an M1 tenure.
    master_req  = 2'b10;
    hba_xferack = 1'b0;
    tick();
    check("t6_m1_grant", 32'(master_grant), 32'h2);
    tick();
    check_bus_m1("t6_m1_bus");
    #1;
    hba_reset_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(master_grant), 32'h0);
    check_idle("t6_rst_bus");
    master_req = 2'b11;
    #3;
    hba_reset_n = 1'b1;
    tick();
    check("t6_m0_first", 32'(master_grant), 32'h1);
    check_bus_m0("t6_m0_bus");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
